// File: rtl/alu_vector_recorder.sv
// alu_vector_recorder
//   Observes ALU transactions and buffers them as 107-bit test-vector words
//   {opcode, funct, add_rshift_type, A, B, Out} in a small circular FIFO.
//   The FIFO drains through a valid/ready stream to a trace sink.
//
// Parameters
//   DEPTH  FIFO entries, power of two, 2..64
//   CNT_W  width of the saturating vector/drop counters
//
// Ports
//   Clock, Reset      rising-edge clock, asynchronous active-high reset
//   cap_valid         sample strobe, one ALU transaction per asserted cycle
//   opcode/funct/add_rshift_type/A/B/Out   fields packed into the word
//   vec_valid/vec_ready/vec_data           head-of-FIFO output stream
//   level             current occupancy (0..DEPTH)
//   vec_count         accepted vectors, saturating
//   drop_count        strobes lost to a full FIFO, saturating
//   overflow          sticky, set on the first drop
//
// Optional feature macro: ALU_REC_DEDUP_EN
//   When defined, a strobe whose word equals the most recently accepted word
//   is ignored (no push, no counter or overflow change).

module alu_vector_recorder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     cap_valid,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct,
   input  logic                     add_rshift_type,
   input  logic [31:0]              A,
   input  logic [31:0]              B,
   input  logic [31:0]              Out,
   output logic                     vec_valid,
   input  logic                     vec_ready,
   output logic [106:0]             vec_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         vec_count,
   output logic [CNT_W-1:0]         drop_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [106:0] word;
   logic [106:0] mem_q [DEPTH];

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;
   logic             overflow_q, overflow_d;

   logic strobe, pop, push, drop, full;

   assign word = {opcode, funct, add_rshift_type, A, B, Out};

`ifdef ALU_REC_DEDUP_EN
   // last_vld_q makes the first strobe after reset always distinct, even
   // when its word happens to equal the cleared register value.
   logic [106:0] last_q, last_d;
   logic         last_vld_q, last_vld_d;

   assign strobe = cap_valid && !(last_vld_q && (word == last_q));

   always_comb begin
      last_d     = last_q;
      last_vld_d = last_vld_q;
      if (push) begin
         last_d     = word;
         last_vld_d = 1'b1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
      end else begin
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
      end
   end
`else
   assign strobe = cap_valid;
`endif

   // Pointer difference is the occupancy; the extra MSB separates full/empty.
   assign level     = wr_ptr_q - rd_ptr_q;
   assign full      = (level == FULL_LVL);
   assign vec_valid = (wr_ptr_q != rd_ptr_q);
   assign pop       = vec_valid && vec_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push      = strobe && (!full || pop);
   assign drop      = strobe && full && !pop;

   assign vec_data   = vec_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
   assign vec_count  = vec_count_q;
   assign drop_count = drop_count_q;
   assign overflow   = overflow_q;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      vec_count_d  = vec_count_q;
      drop_count_d = drop_count_q;
      overflow_d   = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (vec_count_q != CNT_MAX)
            vec_count_d = vec_count_q + CNT_ONE;
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != CNT_MAX)
            drop_count_d = drop_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         vec_count_q  <= '0;
         drop_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         vec_count_q  <= vec_count_d;
         drop_count_q <= drop_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge Clock) begin
      if (push)
         mem_q[wr_ptr_q[AW-1:0]] <= word;
   end

endmodule
